// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants, class codes and FSM encoding for the request arbiter
package nn_pkg;

  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int TMO  = 512;

  localparam logic [1:0] CLS_O    = 2'b00;
  localparam logic [1:0] CLS_X    = 2'b01;
  localparam logic [1:0] CLS_NONE = 2'b10;
  localparam logic [1:0] CLS_ERR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts at ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);

  logic [PW:0] pos;

  // Walk requesters from ptr upward with wrap; the first one asking wins.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(NREQ)) pos = pos - (PW+1)'(NREQ);
      if (!valid && req[pos[PW-1:0]]) begin
        gnt[pos[PW-1:0]] = 1'b1;
        valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nn_req_arbiter.sv
// rtl/nn_req_arbiter.sv - round-robin front end sharing one classifier among requesters
module nn_req_arbiter
  import nn_pkg::state_t, nn_pkg::ST_IDLE, nn_pkg::ST_START, nn_pkg::ST_WAIT,
         nn_pkg::ST_RESP, nn_pkg::CLS_ERR;
#(
  parameter int N    = nn_pkg::N,
  parameter int NREQ = nn_pkg::NREQ,
  parameter int TMO  = nn_pkg::TMO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   resp_valid,
  output logic [1:0]        resp_class,
  output logic              busy,
  output logic [N-1:0]      cls_data,
  output logic              cls_start,
  input  logic              cls_rdy,
  input  logic [1:0]        cls_res,
  output logic              cls_clr,
  output logic              err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO);

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [1:0]      resp_class_q, resp_class_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    cls_data_q, cls_data_d;
  logic            cls_start_q, cls_start_d;
  logic            cls_clr_q, cls_clr_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] pick_gnt;
  logic            pick_valid;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   ptr_nxt;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Binary index of the requester currently being served, for the pointer update.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_q[i]) sel_idx = PW'(i);
    end
  end

  assign ptr_nxt = (sel_idx == PW'(NREQ-1)) ? '0 : sel_idx + PW'(1);

  // Next-state and registered-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    gnt_d        = '0;
    resp_valid_d = '0;
    resp_class_d = resp_class_q;
    busy_d       = busy_q;
    cls_data_d   = cls_data_q;
    cls_start_d  = 1'b0;
    cls_clr_d    = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          sel_d   = pick_gnt;
          busy_d  = 1'b1;
          state_d = ST_START;
          for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) cls_data_d = req_data[i*N +: N];
          end
        end
      end
      ST_START: begin
        cls_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (cls_rdy) begin
          resp_class_d = cls_res;
          resp_valid_d = sel_q;
          state_d      = ST_RESP;
        end else if (cnt_q == CW'(TMO-1)) begin
          resp_class_d = CLS_ERR;
          resp_valid_d = sel_q;
          err_d        = 1'b1;
          cls_clr_d    = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        busy_d  = 1'b0;
        ptr_d   = ptr_nxt;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any request, ena low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      sel_q        <= '0;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      resp_class_q <= '0;
      busy_q       <= 1'b0;
      cls_data_q   <= '0;
      cls_start_q  <= 1'b0;
      cls_clr_q    <= 1'b0;
      err_q        <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_class_q <= resp_class_d;
      busy_q       <= busy_d;
      cls_data_q   <= cls_data_d;
      cls_start_q  <= cls_start_d;
      cls_clr_q    <= cls_clr_d;
      err_q        <= err_d;
    end
  end

  assign gnt        = gnt_q;
  assign resp_valid = resp_valid_q;
  assign resp_class = resp_class_q;
  assign busy       = busy_q;
  assign cls_data   = cls_data_q;
  assign cls_start  = cls_start_q;
  assign cls_clr    = cls_clr_q;
  assign err        = err_q;

endmodule

// File: tb/tb_nn_req_arbiter.sv
// tb/tb_nn_req_arbiter.sv - self-checking bench for nn_req_arbiter
module tb_nn_req_arbiter;
  import nn_pkg::*;

  logic              clk = 1'b0;
  logic              rst, ena;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   gnt, resp_valid;
  logic [1:0]        resp_class;
  logic              busy;
  logic [N-1:0]      cls_data;
  logic              cls_start, cls_rdy;
  logic [1:0]        cls_res;
  logic              cls_clr, err;

  nn_req_arbiter dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .req_data(req_data),
    .gnt(gnt), .resp_valid(resp_valid), .resp_class(resp_class), .busy(busy),
    .cls_data(cls_data), .cls_start(cls_start), .cls_rdy(cls_rdy),
    .cls_res(cls_res), .cls_clr(cls_clr), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int gnt_cnt = 0, start_cnt = 0, rv_cnt = 0;
  bit pending [NREQ];
  logic [N-1:0] data_m [NREQ];
  int mptr = 0;
  int served [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses count once per cycle in which the DUT actually advances.
  task automatic step();
    if (ena) begin
      if (|gnt) gnt_cnt++;
      if (cls_start) start_cnt++;
      if (|resp_valid) rv_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input int k, input logic [N-1:0] d);
    data_m[k] = d;
    req_data[k*N +: N] = d;
    req[k] = 1'b1;
    pending[k] = 1'b1;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++) begin
      if (pending[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  // One transaction: d WAIT cycles before cls_rdy (d >= TMO means never),
  // optional 10-cycle ena stall at WAIT iteration stall_at, optional req blip.
  task automatic serve(input int d, input logic [1:0] res, input int stall_at, input int blip);
    int g, w, hold_bad, g0, s0, r0, n;
    logic [N-1:0] dexp;
    bit tmo;
    g = model_pick();
    if (g < 0) return;
    g0 = gnt_cnt; s0 = start_cnt; r0 = rv_cnt;
    w = 0;
    while (gnt === '0 && w < 8) begin step(); w++; end
    check("gnt", gnt, 64'(1) << g);
    served.push_back(oh_idx(gnt));
    dexp = data_m[g];
    check("gnt_data", cls_data, dexp);
    check("gnt_busy", busy, 1);
    req[g] = 1'b0;
    pending[g] = 1'b0;
    cls_rdy = 1'($urandom_range(0, 1));
    cls_res = 2'($urandom);
    step();
    cls_rdy = 1'b0;
    check("start_pulse", cls_start, 1);
    check("start_no_resp", resp_valid, 0);
    tmo = (d >= TMO);
    n = tmo ? TMO - 1 : d;
    hold_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        ena = 1'b0;
        repeat (10) begin
          step();
          if (cls_data !== dexp || busy !== 1'b1 || resp_valid !== '0) hold_bad++;
        end
        ena = 1'b1;
      end
      if (blip >= 0 && i == 1) begin
        req[blip] = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
          data_m[k] = N'($urandom);
          req_data[k*N +: N] = data_m[k];
        end
      end
      if (blip >= 0 && i == 2) req[blip] = 1'b0;
      step();
      if (cls_data !== dexp || busy !== 1'b1 || resp_valid !== '0 ||
          cls_start !== 1'b0 || err !== 1'b0 || gnt !== '0) hold_bad++;
    end
    check("wait_hold", hold_bad, 0);
    if (!tmo) begin
      cls_rdy = 1'b1;
      cls_res = res;
      step();
      cls_rdy = 1'b0;
      cls_res = 2'($urandom);
      check("resp_valid", resp_valid, 64'(1) << g);
      check("resp_class", resp_class, res);
      check("resp_no_err", {err, cls_clr}, 0);
    end else begin
      step();
      check("tmo_valid", resp_valid, 64'(1) << g);
      check("tmo_class", resp_class, CLS_ERR);
      check("tmo_err_clr", {err, cls_clr}, 2'b11);
    end
    check("resp_busy_data", {busy, cls_data}, {1'b1, dexp});
    mptr = (g + 1) % NREQ;
    step();
    check("post_idle", {busy, err, cls_clr, resp_valid, cls_start}, 0);
    check("gnt_once", gnt_cnt - g0, 1);
    check("start_once", start_cnt - s0, 1);
    check("resp_once", rv_cnt - r0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, d, st, bl, base;
    rst = 1'b1; ena = 1'b1; req = '0; req_data = '0; cls_rdy = 1'b0; cls_res = 2'b00;
    for (int k = 0; k < NREQ; k++) begin pending[k] = 1'b0; data_m[k] = '0; end
    repeat (3) step();
    check("reset_state", {gnt, resp_valid, resp_class, busy, cls_data, cls_start, cls_clr, err}, 0);
    rst = 1'b0;
    step();

    // single request, result x after 20 cycles
    raise(0, 16'hA5A5);
    serve(20, CLS_X, -1, -1);

    // all four at once from ptr 0
    rst = 1'b1; step(); rst = 1'b0; step(); mptr = 0;
    for (int k = 0; k < NREQ; k++) raise(k, N'($urandom));
    served.delete();
    repeat (4) serve($urandom_range(0, 15), 2'($urandom), -1, -1);
    for (int k = 0; k < 4; k++) check("order_all4", served[k], k);

    // 2 waits while 0 is served, 0 re-requests afterwards -> 2 before 0
    served.delete();
    raise(0, N'($urandom)); raise(2, N'($urandom));
    serve(5, CLS_O, -1, -1);
    raise(0, N'($urandom));
    serve(6, CLS_NONE, -1, -1);
    serve(3, CLS_X, -1, -1);
    check("order_rr0", served[0], 0);
    check("order_rr1", served[1], 2);
    check("order_rr2", served[2], 0);

    // timeout, then a normal request still works
    raise(3, N'($urandom));
    serve(TMO, 2'b00, -1, -1);
    raise(1, N'($urandom));
    serve(7, CLS_O, -1, -1);

    // rdy on the very cycle the counter reaches TMO-1: result wins
    raise(2, N'($urandom));
    serve(TMO - 1, CLS_NONE, -1, -1);

    // ena stalls: mid-WAIT, on the cls_start cycle, and during a timeout
    raise(1, N'($urandom));
    serve(30, CLS_O, 5, -1);
    raise(0, N'($urandom));
    serve(4, CLS_X, 0, -1);
    raise(2, N'($urandom));
    serve(TMO, 2'b00, 100, -1);

    // reset mid-WAIT: immediate clear, no response, ptr back to 0
    raise(1, N'($urandom));
    serve(5, CLS_O, -1, -1);
    raise(3, N'($urandom));
    bad = 0;
    while (gnt === '0 && bad < 8) begin step(); bad++; end
    check("rst_pre_gnt", gnt, 4'b1000);
    req[3] = 1'b0; pending[3] = 1'b0;
    repeat (6) step();
    #2 rst = 1'b1;
    #1;
    check("rst_async", {gnt, resp_valid, resp_class, busy, cls_data, cls_start, cls_clr, err}, 0);
    step(); step();
    rst = 1'b0;
    mptr = 0;
    cls_rdy = 1'b1; cls_res = 2'b01;
    bad = 0;
    base = rv_cnt;
    repeat (6) begin
      step();
      cls_rdy = 1'b0;
      if (resp_valid !== '0 || busy !== 1'b0 || gnt !== '0) bad++;
    end
    check("rst_no_resp", bad, 0);
    check("rst_no_resp_cnt", rv_cnt - base, 0);
    served.delete();
    raise(2, N'($urandom)); raise(0, N'($urandom));
    serve(3, CLS_X, -1, -1);
    check("rst_ptr0", served[0], 0);
    serve(3, CLS_O, -1, -1);

    // randomized traffic
    repeat (25) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pending[k] && $urandom_range(0, 1) == 1) raise(k, N'($urandom));
      end
      if (model_pick() < 0) raise($urandom_range(0, NREQ - 1), N'($urandom));
      d  = $urandom_range(0, 40);
      st = (d > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, d - 1) : -1;
      bl = -1;
      if (d >= 3 && $urandom_range(0, 2) == 0) begin
        for (int k = 0; k < NREQ; k++) if (!pending[k]) bl = k;
      end
      serve(d, 2'($urandom), st, bl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
